// File: rtl/fir_pkg.sv
// Shared FIR saturation helpers. The tap and the output stage both use this package,
// so the two always apply the same rounding and saturation rules.
package fir_pkg;

    localparam logic [15:0] SAT_MAX = 16'h7FFF;
    localparam logic [15:0] SAT_MIN = 16'h8001;
    localparam int I_LSB = 0;
    localparam int Q_LSB = 16;

    typedef struct packed {
        logic        sat;
        logic [15:0] val;
    } sat_res_t;

    // Saturation is symmetric: -32768 is clipped to -32767 even when the shift is 0.
    function automatic sat_res_t sat_shift16(input logic [15:0] x, input logic [3:0] sh);
        logic signed [31:0] w;
        sat_res_t r;
        w = {{16{x[15]}}, x};
        w = w <<< sh;
        if (w > 32'sd32767) begin
            r = '{sat: 1'b1, val: SAT_MAX};
        end else if (w < -32'sd32767) begin
            r = '{sat: 1'b1, val: SAT_MIN};
        end else begin
            r = '{sat: 1'b0, val: w[15:0]};
        end
        return r;
    endfunction

endpackage

// File: rtl/fir_out_stage_if.sv
// Stream bundle around the FIR output stage. It carries the chain input and the
// AXI-Stream output toward the packetizer.
interface fir_out_stage_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] s_data;
    logic                  s_valid;
    logic                  s_ready;
    logic [DATA_WIDTH-1:0] m_axis_tdata;
    logic                  m_axis_tvalid;
    logic                  m_axis_tready;
    logic                  m_axis_tlast;

    modport master (
        input  s_data, s_valid, m_axis_tready,
        output s_ready, m_axis_tdata, m_axis_tvalid, m_axis_tlast
    );

    modport slave (
        output s_data, s_valid, m_axis_tready,
        input  s_ready, m_axis_tdata, m_axis_tvalid, m_axis_tlast
    );
endinterface

// File: rtl/fir_out_fifo.sv
// 3-deep first-word-fall-through FIFO. A push is taken when the FIFO is full if a
// pop happens in the same cycle.
module fir_out_fifo #(
    parameter int WIDTH = 33
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    output logic             in_ready,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             out_valid,
    output logic [1:0]       count
);
    logic [WIDTH-1:0] mem [3];
    logic [1:0] wr_ptr, rd_ptr;
    logic do_push, do_pop;

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    assign out_valid = (count != 2'd0);
    assign in_ready  = (count != 2'd3) || pop;
    assign do_push   = push && in_ready;
    assign do_pop    = pop && out_valid;
    assign pop_data  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= 2'd0;
            rd_ptr <= 2'd0;
            count  <= 2'd0;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/fir_out_stage.sv
// FIR output conditioning stage. It decimates the I/Q stream, applies a shift gain with
// symmetric saturation, frames the result with tlast and buffers it for AXI-Stream.
module fir_out_stage #(
    parameter int DATA_WIDTH  = 32,
    parameter int DECIM_WIDTH = 8,
    parameter int FRAME_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    fir_out_stage_if.master        bus,
    input  logic [DECIM_WIDTH-1:0] cfg_decim,
    input  logic [3:0]             cfg_shift,
    input  logic [FRAME_WIDTH-1:0] cfg_frame_len,
    input  logic                   cfg_load,
    output logic [15:0]            sat_count
);
    import fir_pkg::*;

    logic [DECIM_WIDTH-1:0] decim_q, phase, decim_eff, d_eff, phase_eff, phase_nxt;
    logic [FRAME_WIDTH-1:0] flen_q, frame_cnt, flen_eff, frame_eff, frame_nxt;
    logic [3:0]             shift_q, shift_eff;
    logic [15:0]            sat_q, sat_eff, sat_nxt;
    logic                   xfer, keep, last_new;
    sat_res_t               lane_i, lane_q;

    logic                  stage_valid;
    logic [DATA_WIDTH:0]   stage_word;
    logic                  fifo_push, fifo_in_ready, fifo_valid;
    logic [DATA_WIDTH:0]   fifo_word;
    logic [1:0]            fifo_count;

    assign bus.s_ready = !rst && (({1'b0, fifo_count} + {2'b00, stage_valid}) < 3'd3);
    assign xfer        = bus.s_valid && bus.s_ready;
    assign fifo_push   = stage_valid && fifo_in_ready;

    // A load in the same cycle as a transfer applies the new config to that sample.
    always_comb begin
        decim_eff = cfg_load ? cfg_decim     : decim_q;
        shift_eff = cfg_load ? cfg_shift     : shift_q;
        flen_eff  = cfg_load ? cfg_frame_len : flen_q;
        phase_eff = cfg_load ? '0 : phase;
        frame_eff = cfg_load ? '0 : frame_cnt;
        sat_eff   = cfg_load ? '0 : sat_q;
        d_eff     = (decim_eff == '0) ? DECIM_WIDTH'(1) : decim_eff;

        keep     = xfer && (phase_eff == '0);
        lane_i   = sat_shift16(bus.s_data[I_LSB +: 16], shift_eff);
        lane_q   = sat_shift16(bus.s_data[Q_LSB +: 16], shift_eff);
        last_new = (flen_eff != '0) && (frame_eff == flen_eff - FRAME_WIDTH'(1));

        phase_nxt = phase_eff;
        if (xfer) begin
            phase_nxt = (phase_eff == d_eff - DECIM_WIDTH'(1)) ? '0 : phase_eff + DECIM_WIDTH'(1);
        end

        frame_nxt = frame_eff;
        sat_nxt   = sat_eff;
        if (keep) begin
            frame_nxt = last_new ? '0 : frame_eff + FRAME_WIDTH'(1);
            if ((lane_i.sat || lane_q.sat) && (sat_eff != 16'hFFFF)) begin
                sat_nxt = sat_eff + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            decim_q     <= DECIM_WIDTH'(1);
            shift_q     <= 4'd0;
            flen_q      <= '0;
            phase       <= '0;
            frame_cnt   <= '0;
            sat_q       <= 16'd0;
            stage_valid <= 1'b0;
            stage_word  <= '0;
        end else begin
            if (cfg_load) begin
                decim_q <= cfg_decim;
                shift_q <= cfg_shift;
                flen_q  <= cfg_frame_len;
            end
            phase     <= phase_nxt;
            frame_cnt <= frame_nxt;
            sat_q     <= sat_nxt;
            if (keep) begin
                stage_valid <= 1'b1;
                stage_word  <= {last_new, DATA_WIDTH'({lane_q.val, lane_i.val})};
            end else if (fifo_push) begin
                stage_valid <= 1'b0;
            end
        end
    end

    fir_out_fifo #(.WIDTH(DATA_WIDTH + 1)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (stage_word),
        .in_ready  (fifo_in_ready),
        .pop       (bus.m_axis_tready),
        .pop_data  (fifo_word),
        .out_valid (fifo_valid),
        .count     (fifo_count)
    );

    assign bus.m_axis_tvalid = !rst && fifo_valid;
    assign bus.m_axis_tdata  = bus.m_axis_tvalid ? fifo_word[DATA_WIDTH-1:0] : '0;
    assign bus.m_axis_tlast  = bus.m_axis_tvalid && fifo_word[DATA_WIDTH];
    assign sat_count         = rst ? 16'd0 : sat_q;
endmodule

// File: tb/tb_fir_out_stage.sv
// Directed bench for fir_out_stage. Expected values are hand-computed, and the outputs
// are captured at every accepted beat.
module tb_fir_out_stage;
    logic        clk;
    logic        rst;
    logic [7:0]  cfg_decim;
    logic [3:0]  cfg_shift;
    logic [15:0] cfg_frame_len;
    logic        cfg_load;
    logic [15:0] sat_count;

    int n_checks = 0;
    int n_errors = 0;
    int stalls   = 0;
    int idx;
    logic [32:0] got [$];
    logic [32:0] exp4 [6];
    logic [32:0] exp6 [5];

    fir_out_stage_if #(.DATA_WIDTH(32)) bus ();

    fir_out_stage #(.DATA_WIDTH(32), .DECIM_WIDTH(8), .FRAME_WIDTH(16)) dut (
        .clk           (clk),
        .rst           (rst),
        .bus           (bus),
        .cfg_decim     (cfg_decim),
        .cfg_shift     (cfg_shift),
        .cfg_frame_len (cfg_frame_len),
        .cfg_load      (cfg_load),
        .sat_count     (sat_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Beats are captured mid-cycle, when tvalid/tready show the coming handshake.
    always @(negedge clk) begin
        if (bus.m_axis_tvalid && bus.m_axis_tready) begin
            got.push_back({bus.m_axis_tlast, bus.m_axis_tdata});
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [32:0] obs, input logic [32:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input int i, input logic [32:0] exp);
        logic [32:0] v;
        v = (i < got.size()) ? got[i] : 33'bx;
        chk(tag, v, exp);
    endtask

    task automatic send(input logic [31:0] d, input logic ld);
        bit done;
        done = 1'b0;
        bus.s_data  = d;
        bus.s_valid = 1'b1;
        for (int t = 0; t < 50 && !done; t++) begin
            if (bus.s_ready) begin
                cfg_load = ld;
                cyc();
                cfg_load = 1'b0;
                done = 1'b1;
            end else begin
                stalls++;
                cyc();
            end
        end
        if (!done) chk("send_timeout", {32'b0, done}, 33'd1);
    endtask

    task automatic load_cfg(input logic [7:0] d, input logic [3:0] sh, input logic [15:0] len);
        cfg_decim     = d;
        cfg_shift     = sh;
        cfg_frame_len = len;
        cfg_load      = 1'b1;
        cyc();
        cfg_load      = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        bus.s_valid = 1'b0;
        bus.s_data = 32'h0;
        bus.m_axis_tready = 1'b1;
        cfg_decim = 8'd0;
        cfg_shift = 4'd0;
        cfg_frame_len = 16'd0;
        cfg_load = 1'b0;
        repeat (3) cyc();

        // Reset state
        chk("rst_s_ready", {32'b0, bus.s_ready}, 33'd0);
        chk("rst_tvalid", {32'b0, bus.m_axis_tvalid}, 33'd0);
        chk("rst_tdata", {1'b0, bus.m_axis_tdata}, 33'd0);
        chk("rst_tlast", {32'b0, bus.m_axis_tlast}, 33'd0);
        chk("rst_sat", {17'b0, sat_count}, 33'd0);
        rst = 1'b0;
        #1;
        chk("ready_after_rst", {32'b0, bus.s_ready}, 33'd1);

        // 1: pass-through with reset config, latency N+2
        got.delete();
        send(32'h0001_0002, 1'b0);
        bus.s_valid = 1'b0;
        chk("t1_lat_n1", {32'b0, bus.m_axis_tvalid}, 33'd0);
        cyc();
        chk("t1_lat_n2_valid", {32'b0, bus.m_axis_tvalid}, 33'd1);
        chk("t1_lat_n2_data", {1'b0, bus.m_axis_tdata}, 33'h0_0001_0002);
        send(32'hFFFF_8000, 1'b0);
        bus.s_valid = 1'b0;
        repeat (4) cyc();
        chk("t1_count", 33'(got.size()), 33'd2);
        chk_out("t1_out0", 0, 33'h0_0001_0002);
        chk_out("t1_out1", 1, 33'h0_FFFF_8001);
        chk("t1_sat", {17'b0, sat_count}, 33'd1);

        // 2: decimation by 4, continuous input
        load_cfg(8'd4, 4'd0, 16'd0);
        got.delete();
        stalls = 0;
        for (int k = 0; k < 16; k++) send(32'(k), 1'b0);
        bus.s_valid = 1'b0;
        chk("t2_stalls", 33'(stalls), 33'd0);
        repeat (5) cyc();
        chk("t2_count", 33'(got.size()), 33'd4);
        for (int k = 0; k < 4; k++) chk_out("t2_out", k, 33'(4 * k));

        // 3: gain shift 4 with saturation
        load_cfg(8'd1, 4'd4, 16'd0);
        got.delete();
        send(32'hF000_0800, 1'b0);
        send(32'h0000_0010, 1'b0);
        bus.s_valid = 1'b0;
        repeat (5) cyc();
        chk_out("t3_sat_lanes", 0, 33'h0_8001_7FFF);
        chk_out("t3_gain", 1, 33'h0_0000_0100);
        chk("t3_sat_count", {17'b0, sat_count}, 33'd1);

        // 4: framing, frame_len=3, D=2
        load_cfg(8'd2, 4'd0, 16'd3);
        got.delete();
        for (int k = 0; k < 12; k++) send(32'(k), 1'b0);
        bus.s_valid = 1'b0;
        repeat (5) cyc();
        exp4 = '{33'h0_0000_0000, 33'h0_0000_0002, 33'h1_0000_0004,
                 33'h0_0000_0006, 33'h0_0000_0008, 33'h1_0000_000A};
        chk("t4_count", 33'(got.size()), 33'd6);
        for (int k = 0; k < 6; k++) chk_out("t4_out", k, exp4[k]);

        // 5: backpressure
        load_cfg(8'd1, 4'd0, 16'd0);
        bus.m_axis_tready = 1'b0;
        got.delete();
        idx = 0;
        bus.s_data = 32'h100;
        bus.s_valid = 1'b1;
        repeat (8) begin
            if (bus.s_ready) begin
                cyc();
                idx++;
                bus.s_data = 32'h100 + 32'(idx);
            end else begin
                cyc();
            end
        end
        bus.s_valid = 1'b0;
        chk("t5_accepted", 33'(idx), 33'd3);
        chk("t5_s_ready", {32'b0, bus.s_ready}, 33'd0);
        chk("t5_tvalid", {32'b0, bus.m_axis_tvalid}, 33'd1);
        repeat (3) begin
            chk("t5_hold", {bus.m_axis_tlast, bus.m_axis_tdata}, 33'h0_0000_0100);
            cyc();
        end
        chk("t5_none_early", 33'(got.size()), 33'd0);
        bus.m_axis_tready = 1'b1;
        repeat (6) cyc();
        chk("t5_drain_count", 33'(got.size()), 33'd3);
        for (int k = 0; k < 3; k++) chk_out("t5_drain", k, 33'(32'h100 + k));

        // 6a: cfg_load mid-stream D 4->2 with frame_len 3
        load_cfg(8'd4, 4'd0, 16'd3);
        got.delete();
        for (int k = 0; k < 6; k++) send(32'(k), 1'b0);
        cfg_decim = 8'd2;
        cfg_frame_len = 16'd3;
        send(32'd6, 1'b1);
        for (int k = 7; k < 11; k++) send(32'(k), 1'b0);
        bus.s_valid = 1'b0;
        repeat (5) cyc();
        exp6 = '{33'h0_0000_0000, 33'h0_0000_0004, 33'h0_0000_0006,
                 33'h0_0000_0008, 33'h1_0000_000A};
        chk("t6a_count", 33'(got.size()), 33'd5);
        for (int k = 0; k < 5; k++) chk_out("t6a_out", k, exp6[k]);

        // 6b: reset with the FIFO full
        load_cfg(8'd1, 4'd0, 16'd0);
        bus.m_axis_tready = 1'b0;
        got.delete();
        send(32'h0000_8000, 1'b0);
        send(32'h0000_0001, 1'b0);
        send(32'h0000_0002, 1'b0);
        bus.s_valid = 1'b0;
        repeat (2) cyc();
        chk("t6b_full_ready", {32'b0, bus.s_ready}, 33'd0);
        chk("t6b_sat_pre", {17'b0, sat_count}, 33'd1);
        rst = 1'b1;
        cyc();
        chk("t6b_rst_tvalid", {32'b0, bus.m_axis_tvalid}, 33'd0);
        chk("t6b_rst_sat", {17'b0, sat_count}, 33'd0);
        rst = 1'b0;
        bus.m_axis_tready = 1'b1;
        repeat (5) cyc();
        chk("t6b_no_emit", 33'(got.size()), 33'd0);
        chk("t6b_ready_after", {32'b0, bus.s_ready}, 33'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/fir_out_stage.md
# fir_out_stage

Output conditioning stage placed directly after the last tap of the complex FIR chain. It consumes the chain's packed I/Q accumulator stream, decimates it by a programmable factor, and applies a programmable power-of-two gain with symmetric saturation. It frames the result with `tlast` and presents it on an AXI-Stream master port toward the DMA/packetizer, with full backpressure support.

## Interface
Parameters:
- `DATA_WIDTH`, 32: packed sample width; I in `[15:0]`, Q in `[31:16]`, each signed Q1.15.
- `DECIM_WIDTH`, 8: width of the decimation-factor field.
- `FRAME_WIDTH`, 16: width of the frame-length field and frame counter.

Ports:
- `clk`, in, 1: sole clock.
- `rst`, in, 1: reset, active-high, synchronous.
- `s_data`, in, `DATA_WIDTH`: accumulator output of the last tap.
- `s_valid`, in, 1: `s_data` valid.
- `s_ready`, out, 1: stage accepts `s_data`.
- `cfg_decim`, in, `DECIM_WIDTH`: decimation factor D. A value of 0 is treated as 1.
- `cfg_shift`, in, 4: left gain shift, 0–15.
- `cfg_frame_len`, in, `FRAME_WIDTH`: output samples per frame. A value of 0 means `tlast` is never asserted.
- `cfg_load`, in, 1: one-cycle pulse that latches all `cfg_*` fields into shadow registers.
- `m_axis_tdata`, out, `DATA_WIDTH`: conditioned sample.
- `m_axis_tvalid`, out, 1: output valid.
- `m_axis_tready`, in, 1: downstream ready.
- `m_axis_tlast`, out, 1: last sample of the frame.
- `sat_count`, out, 16: number of kept samples in which either lane saturated. The counter sticks at `16'hFFFF`.

## Operation
- **Input handshake:** a transfer occurs when `s_valid && s_ready`. `s_ready = (fifo_count + stage_valid) < 3`.
- **Decimation:** a `phase` counter runs 0..D-1 and advances on each input transfer. Only the sample taken at `phase == 0` is kept. Other samples are accepted and dropped, and consume no buffer space.
- **Gain, per lane:** form the 32-bit value `x <<< cfg_shift`.
  - If the result is > 32767, the lane becomes `16'h7FFF`.
  - If the result is < -32767, the lane becomes `16'h8001`.
  - Otherwise the lane is the low 16 bits.
  - `-32768` at shift 0 also maps to `16'h8001`. This keeps saturation symmetric and consistent with the taps.
- **Saturation count:** `sat_count` increments by 1 per kept sample if either lane saturated.
- **Framing:** `frame_cnt` advances on each kept sample. When `frame_len != 0` and `frame_cnt == frame_len-1`, `tlast` is set and `frame_cnt` returns to 0. `tlast` travels with its data as a 33-bit FIFO word.
- **Pipeline:** one stage register (gain/sat/tlast), then a 3-deep first-word-fall-through FIFO driving `m_axis_*`. A FIFO word is popped on `m_axis_tvalid && m_axis_tready`.
- **Configuration load:** `cfg_load` latches the shadow config and clears `phase`, `frame_cnt` and `sat_count`. Samples already in the stage register or FIFO keep their old gain and `tlast`. If `cfg_load` coincides with an input transfer, the new config applies to that sample, and that sample counts as `phase == 0` and `frame_cnt == 0`.
- **Reset values:** shadow config is D=1, shift=0, frame_len=0.

## Timing
- Outputs during `rst`: `s_ready=0`, `m_axis_tvalid=0`, `m_axis_tlast=0`, `m_axis_tdata=0`, `sat_count=0`. All counters and the FIFO are empty or zero.
- `s_ready` is 1 on the first cycle after `rst` deasserts.
- Latency: a kept sample accepted in cycle N appears with `m_axis_tvalid=1` in cycle N+2.
- Throughput: one sample per cycle sustained while `m_axis_tready=1`.
- Backpressure: with `m_axis_tready=0`, exactly 3 kept samples are absorbed, then `s_ready` falls. `m_axis_tdata` and `m_axis_tlast` hold stable while `m_axis_tvalid && !m_axis_tready`.
- FIFO full with a simultaneous pop and push: both occur and the count is unchanged.
- `rst` mid-operation: buffered samples are discarded and no partial frame is emitted.
- `frame_cnt` and `phase` wrap exactly as described above, with no extra idle cycle.

## Structure
- Shared package `fir_pkg`:
  - constants `SAT_MAX = 16'h7FFF` and `SAT_MIN = 16'h8001`;
  - lane field offsets `I_LSB = 0` and `Q_LSB = 16`;
  - function `sat_shift16(x, sh)`. This package is shared with the tap so saturation rules stay identical.
- Sub-module `fir_out_fifo`: 3-deep, 33-bit first-word-fall-through FIFO with a count output. Its handshake is independent of the gain logic.

## Test plan
1. **Pass-through:** D=1, shift=0, frame_len=0; send I/Q `0x0001_0002`, `0xFFFF_8000` with `m_axis_tready=1` → outputs `0x0001_0002`, then `0xFFFF_8001` at N+2; `sat_count=1`; `tlast` never asserted.
2. **Decimation:** D=4; feed I=0..15, Q=0 continuously → outputs I=0,4,8,12; `s_ready` stays 1 throughout.
3. **Gain saturation:** shift=4; I=`0x0800`, Q=`0xF000` → I=`0x7FFF`, Q=`0x8001`; I=`0x0010` → `0x0100`; `sat_count` = 1 after these two samples.
4. **Framing:** frame_len=3, D=2; feed 12 samples → 6 outputs with `tlast` on output 3 and output 6 only.
5. **Backpressure:** `m_axis_tready=0` while `s_valid=1` → exactly 3 samples accepted, then `s_ready=0` and `m_axis_tdata` stable; release `m_axis_tready` → samples drain in order with none lost or duplicated.
6. **Mid-stream events:** `cfg_load` mid-stream changing D from 4 to 2 → the first post-load input sample is kept and `frame_cnt` restarts. Separately, assert `rst` with the FIFO full → next cycle `m_axis_tvalid=0` and `sat_count=0`.
